rv32m_div_unit: RTL
===================

Name: rv32m_div_unit

Overview:
- Iterative multi-cycle divider for the EX stage of the pipelined RV32 core. Executes DIV/DIVU/REM/REMU.
- Drives `stall`, which is inverted to form the `load` enable of the PC, IF/ID and ID/EX pipeline registers. The pipeline freezes while a division is in flight.
- Result is consumed by the EX/MEM register in the cycle `done` is high.

Parameters:
- N, 32, operand/result width in bits (N >= 2).
- CW, $clog2(N), iteration counter width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  division request (EX instruction is M-ext divide); level, held by the stalled pipeline.
- op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- dividend  input  N  rs1 value, sampled when start accepted.
- divisor  input  N  rs2 value, sampled when start accepted.
- result  output  N  registered quotient/remainder.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse, result valid.
- stall  output  1  pipeline freeze request (load = ~stall).

Behaviour:
- Interface: one clock `clk`; reset `rst`, asynchronous, active-high. Reset forces state=IDLE, result=0, done=0, busy=0, counter=0, internal remainder/quotient=0.
- States:
  - IDLE -> CALC on start (normal case).
  - IDLE -> DONE on start (special case).
  - CALC -> DONE when counter == N-1.
  - DONE -> IDLE unconditionally.
- Acceptance, at the clock edge with start=1 in IDLE:
  - Latch op and signedness (op[0]==0 means signed).
  - Latch |dividend| and |divisor| (absolute values for signed ops; raw values for unsigned).
  - Latch quotient sign = sign(dividend) XOR sign(divisor). Latch remainder sign = sign(dividend).
  - Clear counter.
- Special cases, decided at acceptance, go straight to DONE:
  - divisor == 0: DIV/DIVU result = all ones; REM/REMU result = dividend, unmodified.
  - Signed overflow (dividend == 2^(N-1), divisor == all ones, signed op): DIV result = dividend; REM result = 0.
- CALC: restoring shift-subtract, one quotient bit per cycle, MSB first.
  - Partial remainder is N+1 bits to hold the borrow.
  - Counter increments each cycle.
- Transition into DONE from CALC:
  - result is loaded with quotient or remainder per op.
  - Signed ops apply two's-complement negation per the latched sign.
  - Remainder is zero when the magnitude is 0 (no -0 issue).
- DONE: done=1 for exactly one cycle. start is ignored in DONE, so a still-asserted start from the same instruction never retriggers.
- result holds its value until the next completion.
- stall = (state==IDLE && start) || state==CALC. It is combinational and low in DONE, so the pipeline advances at the end of the done cycle.
- Latency, start first high in cycle t:
  - Normal op: stall high for cycles t..t+N (N+1 cycles); done and result valid in cycle t+N+1.
  - Special case: stall high in cycle t only; done in cycle t+1.
- Back-to-back: a new start seen in the IDLE cycle following DONE is accepted normally.
- Reset mid-operation: immediate abort, no done pulse; result reads 0 after reset.
- Operand changes after acceptance have no effect.

Test Plan:
- DIVU 100 / 7, start at cycle t -> stall high t..t+32, done only at t+33, result=14; REMU same operands -> 2.
- DIV -20 / 3 -> 0xFFFFFFFA (-6); REM -20 / 3 -> 0xFFFFFFFE (-2); DIV 20 / -3 -> 0xFFFFFFFA; REM 20 / -3 -> 2.
- DIVU 0x12345678 / 0 -> done at t+1, result=0xFFFFFFFF; REM 5 / 0 -> 5; DIV -7 / 0 -> 0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF -> done at t+1, result=0x80000000; REM same operands -> 0.
- Assert rst in 10th CALC cycle -> busy=0, stall=0, result=0 immediately; no done pulse; a subsequent DIVU 9/3 -> 3 with full latency.
- Hold start high through DONE, then IDLE with new operands 50/5 DIVU -> exactly one done per division, second result=10, done spacing = N+2 cycles.

Source files
------------

// File: rtl/rv32m_div_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : rv32m_div_unit_if
// Description : Request/response bundle between the EX stage and the
//               iterative RV32M divider.
// Revision    : 1.0 - initial release
// ============================================================================
interface rv32m_div_unit_if #(
    parameter int N = 32
);
    logic         start;
    logic [1:0]   op;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic [N-1:0] result;
    logic         busy;
    logic         done;
    logic         stall;

    // Pipeline side: issues the divide and consumes the result / stall.
    modport master (
        output start, op, dividend, divisor,
        input  result, busy, done, stall
    );

    // Divider side.
    modport slave (
        input  start, op, dividend, divisor,
        output result, busy, done, stall
    );
endinterface
`default_nettype wire

// File: rtl/rv32m_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : rv32m_div_unit
// Description : Iterative restoring divider for DIV/DIVU/REM/REMU. One
//               quotient bit per cycle; freezes the pipeline while busy.
//               Divide-by-zero and signed overflow complete in one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module rv32m_div_unit #(
    parameter int N  = 32,
    parameter int CW = $clog2(N)
) (
    input  wire logic         clk,
    input  wire logic         rst,
    rv32m_div_unit_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CW-1:0] c_last_cnt = CW'(N - 1);
    localparam logic [N-1:0]  c_int_min  = {1'b1, {(N-1){1'b0}}};

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [N-1:0]  r_rem;      // partial remainder magnitude
    logic [N-1:0]  r_quo;      // dividend bits shift out, quotient bits shift in
    logic [N-1:0]  r_dvs;      // divisor magnitude
    logic          r_rem_sel;  // 1: REM/REMU, 0: DIV/DIVU
    logic          r_qneg;
    logic          r_rneg;
    logic [N-1:0]  r_result;

    // Operand conditioning at acceptance (op[0]==0 means signed).
    logic          w_signed;
    logic          w_a_neg;
    logic          w_b_neg;
    logic [N-1:0]  w_a_abs;
    logic [N-1:0]  w_b_abs;
    logic          w_b_zero;
    logic          w_ovf;
    logic          w_special;
    logic [N-1:0]  w_special_res;

    assign w_signed  = ~bus.op[0];
    assign w_a_neg   = w_signed & bus.dividend[N-1];
    assign w_b_neg   = w_signed & bus.divisor[N-1];
    assign w_a_abs   = w_a_neg ? (~bus.dividend + 1'b1) : bus.dividend;
    assign w_b_abs   = w_b_neg ? (~bus.divisor + 1'b1) : bus.divisor;
    assign w_b_zero  = (bus.divisor == '0);
    assign w_ovf     = w_signed && (bus.dividend == c_int_min) && (&bus.divisor);
    assign w_special = w_b_zero | w_ovf;
    assign w_special_res = w_b_zero ? (bus.op[1] ? bus.dividend : '1)
                                    : (bus.op[1] ? '0 : bus.dividend);

    // One restoring step: the shifted remainder needs N+1 bits so the borrow
    // of the trial subtraction is visible in the top bit.
    logic [N:0]    w_shift;
    logic [N:0]    w_diff;
    logic          w_qbit;
    logic [N-1:0]  w_next_rem;
    logic [N-1:0]  w_next_quo;
    logic [N-1:0]  w_quo_out;
    logic [N-1:0]  w_rem_out;

    assign w_shift    = {r_rem, r_quo[N-1]};
    assign w_diff     = w_shift - {1'b0, r_dvs};
    assign w_qbit     = ~w_diff[N];
    assign w_next_rem = w_qbit ? w_diff[N-1:0] : w_shift[N-1:0];
    assign w_next_quo = {r_quo[N-2:0], w_qbit};
    // Negating a zero magnitude yields zero, so no -0 can appear.
    assign w_quo_out  = r_qneg ? (~w_next_quo + 1'b1) : w_next_quo;
    assign w_rem_out  = r_rneg ? (~w_next_rem + 1'b1) : w_next_rem;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; start is only looked at in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (bus.start) w_state_nxt = w_special ? S_DONE : S_CALC;
            S_CALC: if (r_cnt == c_last_cnt) w_state_nxt = S_DONE;
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: latch operands on acceptance, iterate in CALC, load result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_dvs     <= '0;
            r_rem_sel <= 1'b0;
            r_qneg    <= 1'b0;
            r_rneg    <= 1'b0;
            r_result  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_rem_sel <= bus.op[1];
                        r_qneg    <= w_a_neg ^ w_b_neg;
                        r_rneg    <= w_a_neg;
                        r_quo     <= w_a_abs;
                        r_dvs     <= w_b_abs;
                        r_rem     <= '0;
                        r_cnt     <= '0;
                        if (w_special) r_result <= w_special_res;
                    end
                end
                S_CALC: begin
                    r_rem <= w_next_rem;
                    r_quo <= w_next_quo;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_last_cnt) begin
                        r_result <= r_rem_sel ? w_rem_out : w_quo_out;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.result = r_result;
    assign bus.busy   = (r_state != S_IDLE);
    assign bus.done   = (r_state == S_DONE);
    assign bus.stall  = ((r_state == S_IDLE) && bus.start) || (r_state == S_CALC);
endmodule
`default_nettype wire
